// File: rtl/dpll_loop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpll_loop_ctrl_pkg
// Brief    : Shared types and helpers for the DPLL loop controller
//            (FSM state encoding, phase-detector polarity, queue limit).
// Revision : 1.0 - initial release
// ============================================================================
package dpll_loop_ctrl_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Phase-detector polarity: lead counts up, lag counts down
    localparam logic c_PD_LEAD = 1'b1;
    localparam logic c_PD_LAG  = 1'b0;

    // Largest magnitude the signed pending queue may hold
    function automatic int pend_limit(input int pend_w);
        return (1 << (pend_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpll_loop_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dpll_loop_ctrl_if
// Brief    : Phase-detector input and ID-counter output bundle of the loop
//            controller. master = phase-detector side, slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface dpll_loop_ctrl_if #(
    parameter int PEND_W = 4
);
    logic                     pd_valid;
    logic                     pd_lead;
    logic                     inc_out;
    logic                     dec_out;
    logic signed [PEND_W-1:0] pending;
    logic                     locked;
    logic                     overflow;

    modport master (
        output pd_valid, pd_lead,
        input  inc_out, dec_out, pending, locked, overflow
    );

    modport slave (
        input  pd_valid, pd_lead,
        output inc_out, dec_out, pending, locked, overflow
    );
endinterface
`default_nettype wire

// File: rtl/dpll_loop_ctrl_k_counter.sv
`default_nettype none
// ============================================================================
// Module   : dpll_loop_ctrl_k_counter
// Brief    : K-counter loop filter. Integrates lead/lag samples in a signed
//            accumulator and flags a carry at +k or a borrow at -k.
// Revision : 1.0 - initial release
// ============================================================================
module dpll_loop_ctrl_k_counter
    import dpll_loop_ctrl_pkg::*;
#(
    parameter int K_W = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           i_clear,
    input  wire logic           i_active,
    input  wire logic [K_W-1:0] i_k,
    input  wire logic           i_pd_valid,
    input  wire logic           i_pd_lead,
    output logic                o_carry,
    output logic                o_borrow
);

    typedef logic signed [K_W:0]   acc_t;
    typedef logic signed [K_W+1:0] ext_t;

    acc_t r_acc;
    ext_t w_acc;
    ext_t w_k;
    ext_t w_up;
    ext_t w_dn;

    // One extra bit of headroom so +k and -k compare without wrap
    assign w_acc = ext_t'(r_acc);
    assign w_k   = ext_t'({2'b00, i_k});
    assign w_up  = w_acc + ext_t'(1);
    assign w_dn  = w_acc - ext_t'(1);

    assign o_carry  = i_active && i_pd_valid && (i_pd_lead == c_PD_LEAD) && (w_up == w_k);
    assign o_borrow = i_active && i_pd_valid && (i_pd_lead == c_PD_LAG)  && (w_dn == -w_k);

    // Accumulate samples; wrap to zero on carry/borrow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_active && i_pd_valid) begin
            if (o_carry || o_borrow)
                r_acc <= '0;
            else if (i_pd_lead == c_PD_LEAD)
                r_acc <= acc_t'(w_up);
            else
                r_acc <= acc_t'(w_dn);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpll_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpll_loop_ctrl
// Brief    : DPLL loop filter and pulse scheduler ahead of the ID counter.
//            Queues carry/borrow events as a signed count and issues them as
//            single-clock inc/dec pulses spaced GAP clocks apart.
// Revision : 1.0 - initial release
// ============================================================================
module dpll_loop_ctrl
    import dpll_loop_ctrl_pkg::*;
#(
    parameter int K_W      = 8,
    parameter int PEND_W   = 4,
    parameter int GAP      = 4,
    parameter int LOCK_CYC = 256,
    parameter int LOCK_W   = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           enable,
    input  wire logic [K_W-1:0] k_mod,
    dpll_loop_ctrl_if.slave     bus
);

    typedef logic signed [PEND_W-1:0] pend_t;
    typedef logic signed [PEND_W:0]   pext_t;

    localparam pext_t             c_LIM_P    = pext_t'(pend_limit(PEND_W));
    localparam pext_t             c_LIM_N    = -c_LIM_P;
    localparam logic [3:0]        c_GAP_LOAD = 4'(GAP - 2);
    localparam logic [LOCK_W-1:0] c_LOCK_CYC = LOCK_W'(LOCK_CYC);

    state_t            r_state;
    logic [K_W-1:0]    r_k;
    pend_t             r_pending;
    logic [3:0]        r_gap_cnt;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_inc;
    logic              r_dec;
    logic              r_locked;
    logic              r_overflow;

    logic              w_clear;
    logic              w_active;
    logic              w_carry;
    logic              w_borrow;
    logic              w_event;
    logic              w_issue;
    logic              w_sat;
    pext_t             w_ev;
    pext_t             w_iss;
    pext_t             w_keep;
    pext_t             w_net;
    pend_t             w_pend_next;
    logic [LOCK_W-1:0] w_lock_inc;

    // Dropping enable acts on the very next edge, whatever the state
    assign w_clear  = !enable || (r_state == ST_IDLE);
    assign w_active = !w_clear;

    dpll_loop_ctrl_k_counter #(
        .K_W        (K_W)
    ) u_k_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_active   (w_active),
        .i_k        (r_k),
        .i_pd_valid (bus.pd_valid),
        .i_pd_lead  (bus.pd_lead),
        .o_carry    (w_carry),
        .o_borrow   (w_borrow)
    );

    assign w_event    = w_carry | w_borrow;
    assign w_issue    = w_active && (r_state == ST_RUN) && (r_pending != '0);
    assign w_lock_inc = (r_lock_cnt == c_LOCK_CYC) ? r_lock_cnt : r_lock_cnt + 1'b1;

    // Net queue update: event and issue fold into one step; an event that
    // would push the net past the limit is dropped, the issue still counts
    always_comb begin
        w_ev = '0;
        if (w_carry)
            w_ev = pext_t'(1);
        else if (w_borrow)
            w_ev = pext_t'(-1);
        w_iss = '0;
        if (w_issue)
            w_iss = r_pending[PEND_W-1] ? pext_t'(-1) : pext_t'(1);
        w_keep      = pext_t'(r_pending) - w_iss;
        w_net       = w_keep + w_ev;
        w_sat       = (w_net > c_LIM_P) || (w_net < c_LIM_N);
        w_pend_next = w_sat ? pend_t'(w_keep) : pend_t'(w_net);
    end

    // Scheduler FSM with queue, gap timer, lock counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_k        <= K_W'(1);
            r_pending  <= '0;
            r_gap_cnt  <= '0;
            r_lock_cnt <= '0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_pending  <= '0;
            r_gap_cnt  <= '0;
            r_lock_cnt <= '0;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
            if (r_state == ST_IDLE)
                r_k <= (k_mod == '0) ? K_W'(1) : k_mod;
            r_state <= (enable && (r_state == ST_IDLE)) ? ST_RUN : ST_IDLE;
        end else begin
            r_pending  <= w_pend_next;
            r_overflow <= r_overflow | w_sat;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            if (w_event) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end else begin
                r_lock_cnt <= w_lock_inc;
                r_locked   <= (w_lock_inc == c_LOCK_CYC);
            end
            case (r_state)
                ST_RUN: begin
                    if (w_issue) begin
                        r_state <= ST_ISSUE;
                        r_inc   <= !r_pending[PEND_W-1];
                        r_dec   <= r_pending[PEND_W-1];
                    end
                end
                ST_ISSUE: begin
                    r_state   <= ST_GAP;
                    r_gap_cnt <= c_GAP_LOAD;
                end
                ST_GAP: begin
                    if (r_gap_cnt <= 4'd1) begin
                        r_state   <= ST_RUN;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.inc_out  = r_inc;
    assign bus.dec_out  = r_dec;
    assign bus.pending  = r_pending;
    assign bus.locked   = r_locked;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dpll_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpll_loop_ctrl
// Brief    : Self-checking bench for dpll_loop_ctrl: vector table for the
//            pulse-spacing sequence plus directed corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpll_loop_ctrl;
    import dpll_loop_ctrl_pkg::*;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] k_mod  = 8'd0;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic prev_pulse = 1'b0;

    dpll_loop_ctrl_if #(.PEND_W(4)) bus ();

    dpll_loop_ctrl #(
        .K_W      (8),
        .PEND_W   (4),
        .GAP      (4),
        .LOCK_CYC (256),
        .LOCK_W   (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .k_mod  (k_mod),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic              lead;
        logic              e_inc;
        logic              e_dec;
        logic signed [3:0] e_pend;
    } vec_t;

    vec_t tv [20];

    // Watch for inc/dec overlap or back-to-back pulses throughout the run
    always @(negedge clk) begin
        if (!reset) begin
            prev_pulse = 1'b0;
        end else begin
            if (bus.inc_out && bus.dec_out)
                viol++;
            if ((bus.inc_out || bus.dec_out) && prev_pulse)
                viol++;
            prev_pulse = bus.inc_out || bus.dec_out;
        end
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic v, input logic lead);
        bus.pd_valid = v;
        bus.pd_lead  = lead;
        tick();
    endtask

    task automatic tick_cnt(inout int ni, inout int nd);
        tick();
        ni += int'(bus.inc_out);
        nd += int'(bus.dec_out);
    endtask

    // Pass through IDLE with the given modulus, leave the FSM in RUN
    task automatic start(input logic [7:0] k);
        enable       = 1'b0;
        bus.pd_valid = 1'b0;
        bus.pd_lead  = 1'b0;
        k_mod        = k;
        tick();
        tick();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        int ni;
        int nd;

        // k_mod=1, five leads: pulses at E1,E5,E9,E13,E17, queue peaks at 4
        tv = '{
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'sd1}, '{1'b1, 1'b1, 1'b1, 1'b0, 4'sd1},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'sd2}, '{1'b1, 1'b1, 1'b0, 1'b0, 4'sd3},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'sd4}, '{1'b0, 1'b0, 1'b1, 1'b0, 4'sd3},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd3}, '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd3},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd3}, '{1'b0, 1'b0, 1'b1, 1'b0, 4'sd2},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd2}, '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd2},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd2}, '{1'b0, 1'b0, 1'b1, 1'b0, 4'sd1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd1}, '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd1}, '{1'b0, 1'b0, 1'b1, 1'b0, 4'sd0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd0}, '{1'b0, 1'b0, 1'b0, 1'b0, 4'sd0}
        };

        bus.pd_valid = 1'b0;
        bus.pd_lead  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_inc",  32'(bus.inc_out),  0);
        chk("rst_dec",  32'(bus.dec_out),  0);
        chk("rst_pend", 32'(bus.pending),  0);
        chk("rst_lock", 32'(bus.locked),   0);
        chk("rst_ovf",  32'(bus.overflow), 0);
        chk("rst_state_idle", 32'(dut.r_state == ST_IDLE), 1);
        #2 reset = 1'b1;

        // k_mod=4: carry on the 4th lead, inc_out one clock later
        start(8'd4);
        for (int i = 0; i < 3; i++) begin
            samp(1'b1, 1'b1);
            chk($sformatf("k4_pend[%0d]", i), 32'($signed(bus.pending)), 0);
        end
        samp(1'b1, 1'b1);
        chk("k4_carry_pend", 32'($signed(bus.pending)), 1);
        chk("k4_inc_early",  32'(bus.inc_out), 0);
        samp(1'b0, 1'b0);
        chk("k4_inc_pulse",  32'(bus.inc_out), 1);
        chk("k4_pend_after", 32'($signed(bus.pending)), 0);
        tick();
        chk("k4_inc_end",    32'(bus.inc_out), 0);

        // Table: pulse spacing with k_mod=1
        start(8'd1);
        for (int i = 0; i < 20; i++) begin
            samp(tv[i].v, tv[i].lead);
            chk($sformatf("tbl_inc[%0d]", i),  32'(bus.inc_out), 32'(tv[i].e_inc));
            chk($sformatf("tbl_dec[%0d]", i),  32'(bus.dec_out), 32'(tv[i].e_dec));
            chk($sformatf("tbl_pend[%0d]", i), 32'($signed(bus.pending)), 32'(tv[i].e_pend));
        end

        // Lead then lag while in GAP cancel: a single inc pulse overall
        start(8'd1);
        ni = 0;
        nd = 0;
        bus.pd_valid = 1'b1; bus.pd_lead = 1'b1; tick_cnt(ni, nd);
        bus.pd_valid = 1'b0; bus.pd_lead = 1'b0; tick_cnt(ni, nd);
        bus.pd_valid = 1'b1; bus.pd_lead = 1'b1; tick_cnt(ni, nd);
        bus.pd_valid = 1'b1; bus.pd_lead = 1'b0; tick_cnt(ni, nd);
        bus.pd_valid = 1'b0;
        for (int i = 0; i < 20; i++)
            tick_cnt(ni, nd);
        chk("cancel_inc_count", ni, 1);
        chk("cancel_dec_count", nd, 0);
        chk("cancel_pend", 32'($signed(bus.pending)), 0);

        // Saturation: 12 back-to-back leads hold the queue at +7
        start(8'd1);
        for (int i = 0; i < 12; i++)
            samp(1'b1, 1'b1);
        bus.pd_valid = 1'b0;
        chk("sat_pend", 32'($signed(bus.pending)), 7);
        chk("sat_ovf",  32'(bus.overflow), 1);
        enable = 1'b0;
        tick();
        tick();
        chk("sat_ovf_clear",  32'(bus.overflow), 0);
        chk("sat_pend_clear", 32'($signed(bus.pending)), 0);

        // Lock after 256 quiet clocks; a carry drops it on the same edge
        start(8'd1);
        for (int i = 0; i < 255; i++)
            tick();
        chk("lock_255", 32'(bus.locked), 0);
        tick();
        chk("lock_256", 32'(bus.locked), 1);
        samp(1'b1, 1'b1);
        bus.pd_valid = 1'b0;
        chk("lock_drop", 32'(bus.locked), 0);

        // enable=0 mid-GAP with pending=3
        start(8'd1);
        for (int i = 0; i < 4; i++)
            samp(1'b1, 1'b1);
        bus.pd_valid = 1'b0;
        chk("midgap_pend3", 32'($signed(bus.pending)), 3);
        enable = 1'b0;
        tick();
        tick();
        chk("dis_inc",  32'(bus.inc_out), 0);
        chk("dis_dec",  32'(bus.dec_out), 0);
        chk("dis_pend", 32'($signed(bus.pending)), 0);
        chk("dis_lock", 32'(bus.locked), 0);
        chk("dis_ovf",  32'(bus.overflow), 0);
        chk("dis_state_idle", 32'(dut.r_state == ST_IDLE), 1);
        enable = 1'b1;
        ni = 0;
        nd = 0;
        for (int i = 0; i < 20; i++)
            tick_cnt(ni, nd);
        chk("reen_pulses", ni + nd, 0);
        chk("reen_pend", 32'($signed(bus.pending)), 0);

        // Asynchronous reset mid-GAP with pending=3
        start(8'd1);
        for (int i = 0; i < 4; i++)
            samp(1'b1, 1'b1);
        bus.pd_valid = 1'b0;
        chk("rst_midgap_pend3", 32'($signed(bus.pending)), 3);
        #2 reset = 1'b0;
        #1;
        chk("arst_inc",  32'(bus.inc_out), 0);
        chk("arst_pend", 32'($signed(bus.pending)), 0);
        chk("arst_state_idle", 32'(dut.r_state == ST_IDLE), 1);
        tick();
        #2 reset = 1'b1;
        ni = 0;
        nd = 0;
        for (int i = 0; i < 20; i++)
            tick_cnt(ni, nd);
        chk("arst_reen_pulses", ni + nd, 0);
        chk("arst_reen_pend", 32'($signed(bus.pending)), 0);

        chk("no_overlap_or_adjacent", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
